// File: rtl/uart_pkg.sv
// Shared UART link definitions: default baud divider and receiver FSM states.
package uart_pkg;

  localparam int DEFAULT_BAUD_DIV = 2604;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RECEIVE
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes RX, validates the start bit at mid-bit,
// samples data mid-bit and presents each byte with a sticky rdy flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);

  localparam logic [11:0] BAUD_RELOAD = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF_RELOAD = 12'(HALF_DIV - 1);

  rx_state_t   state;
  logic        sync1, sync2, sync_prev;
  logic [11:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift;
  logic        rx_s, start_edge, sample;

  assign rx_s       = sync2;
  assign start_edge = sync_prev & ~sync2;
  assign sample     = (state != IDLE) && (baud_cnt == '0);

  // Synchronizer and edge flops preset high so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync1     <= RX;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      rx_data  <= '0;
      rdy      <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      if (clr_rdy) rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state    <= START;
            baud_cnt <= HALF_RELOAD;
          end
        end
        START: begin
          if (sample) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state    <= RECEIVE;
              bit_cnt  <= '0;
              baud_cnt <= BAUD_RELOAD;
            end
          end else begin
            baud_cnt <= baud_cnt - 12'd1;
          end
        end
        RECEIVE: begin
          if (sample) begin
            baud_cnt <= BAUD_RELOAD;
            bit_cnt  <= bit_cnt + 4'd1;
            // Ninth sample is the stop bit; the completion assignment to rdy overrides clr_rdy.
            if (bit_cnt == 4'd8) begin
              rx_data <= shift;
              frm_err <= ~rx_s;
              rdy     <= 1'b1;
              state   <= IDLE;
            end else begin
              shift <= {rx_s, shift[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt - 12'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx using a short baud divider to keep runs small.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BAUD = 16;
  localparam int HALF = BAUD / 2;
  // RX fall driven 1 time unit after an edge completes on edge 3 + HALF + 9*BAUD.
  localparam int DONE_EDGE = 3 + HALF + 9 * BAUD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rx #(.BAUD_DIV(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .clr_rdy(clr_rdy),
    .rx_data(rx_data), .rdy(rdy), .frm_err(frm_err)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    RX = b;
    tick(BAUD);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    tick(1);
    clr_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; RX = 1'b1; clr_rdy = 1'b0;
    tick(3);
    checks++;
    if (rx_data !== 8'h00 || rdy !== 1'b0 || frm_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_vals: got data=%h rdy=%b ferr=%b want 00 0 0", rx_data, rdy, frm_err);
    end
    rst_n = 1'b1;
    tick(5);
    checks++;
    if (dut.state !== IDLE || rdy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got state=%0d rdy=%b want IDLE 0", dut.state, rdy);
    end
  endtask

  task automatic test_ideal();
    int cnt;
    cnt = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (rdy !== 1'b1 && cnt < 200) begin
          tick(1);
          cnt++;
        end
      end
    join
    checks++;
    if (cnt < 9 * BAUD + HALF || cnt > (19 * BAUD) / 2 + 4) begin
      failures++;
      $display("FAIL ideal_latency: got %0d clocks want %0d..%0d", cnt, 9 * BAUD + HALF, (19 * BAUD) / 2 + 4);
    end
    checks++;
    if (rdy !== 1'b1 || rx_data !== 8'hA5 || frm_err !== 1'b0) begin
      failures++;
      $display("FAIL ideal_frame: got data=%h rdy=%b ferr=%b want a5 1 0", rx_data, rdy, frm_err);
    end
    pulse_clr();
    checks++;
    if (rdy !== 1'b0 || rx_data !== 8'hA5) begin
      failures++;
      $display("FAIL ideal_clr: got rdy=%b data=%h want 0 a5", rdy, rx_data);
    end
  endtask

  task automatic test_glitch();
    RX = 1'b0;
    tick(3);
    RX = 1'b1;
    checks++;
    if (dut.state !== START) begin
      failures++;
      $display("FAIL glitch_start: got state=%0d want START", dut.state);
    end
    tick(HALF + 6);
    checks++;
    if (dut.state !== IDLE || rdy !== 1'b0 || rx_data !== 8'hA5) begin
      failures++;
      $display("FAIL glitch_reject: got state=%0d rdy=%b data=%h want IDLE 0 a5", dut.state, rdy, rx_data);
    end
    tick(10 * BAUD);
    checks++;
    if (rdy !== 1'b0 || rx_data !== 8'hA5) begin
      failures++;
      $display("FAIL glitch_late: got rdy=%b data=%h want 0 a5", rdy, rx_data);
    end
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0);
    tick(5 * BAUD);
    checks++;
    if (rdy !== 1'b1 || rx_data !== 8'h3C || frm_err !== 1'b1) begin
      failures++;
      $display("FAIL frm_err_frame: got data=%h rdy=%b ferr=%b want 3c 1 1", rx_data, rdy, frm_err);
    end
    pulse_clr();
    tick(5 * BAUD);
    checks++;
    if (rdy !== 1'b0 || dut.state !== IDLE) begin
      failures++;
      $display("FAIL frm_err_low_hold: got rdy=%b state=%0d want 0 IDLE", rdy, dut.state);
    end
    RX = 1'b1;
    tick(2 * BAUD);
    checks++;
    if (rdy !== 1'b0 || rx_data !== 8'h3C || frm_err !== 1'b1) begin
      failures++;
      $display("FAIL frm_err_release: got rdy=%b data=%h ferr=%b want 0 3c 1", rdy, rx_data, frm_err);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h00, 1'b1);
    checks++;
    if (rdy !== 1'b1 || rx_data !== 8'h00 || frm_err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first: got data=%h rdy=%b ferr=%b want 00 1 0", rx_data, rdy, frm_err);
    end
    fork
      send_frame(8'hFF, 1'b1);
      begin
        tick(5 * BAUD);
        checks++;
        if (rx_data !== 8'h00 || rdy !== 1'b1) begin
          failures++;
          $display("FAIL b2b_hold: got data=%h rdy=%b mid-frame want 00 1", rx_data, rdy);
        end
      end
    join
    checks++;
    if (rdy !== 1'b1 || rx_data !== 8'hFF || frm_err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second: got data=%h rdy=%b ferr=%b want ff 1 0", rx_data, rdy, frm_err);
    end
  endtask

  task automatic test_clr_on_completion();
    pulse_clr();
    tick(2);
    fork
      send_frame(8'h81, 1'b1);
      begin
        tick(DONE_EDGE - 1);
        checks++;
        if (rdy !== 1'b0) begin
          failures++;
          $display("FAIL clr_collide_pre: got rdy=%b before completion want 0", rdy);
        end
        clr_rdy = 1'b1;
        tick(1);
        clr_rdy = 1'b0;
        checks++;
        if (rdy !== 1'b1 || rx_data !== 8'h81) begin
          failures++;
          $display("FAIL clr_collide: got rdy=%b data=%h want 1 81", rdy, rx_data);
        end
      end
    join
    checks++;
    if (rdy !== 1'b1 || rx_data !== 8'h81 || frm_err !== 1'b0) begin
      failures++;
      $display("FAIL clr_collide_end: got data=%h rdy=%b ferr=%b want 81 1 0", rx_data, rdy, frm_err);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst_n = 1'b0;
    #1;
    checks++;
    if (rx_data !== 8'h00 || rdy !== 1'b0 || frm_err !== 1'b0 || dut.state !== IDLE) begin
      failures++;
      $display("FAIL reset_mid: got data=%h rdy=%b ferr=%b state=%0d want 00 0 0 IDLE",
               rx_data, rdy, frm_err, dut.state);
    end
    RX = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    send_frame(8'h5A, 1'b1);
    checks++;
    if (rdy !== 1'b1 || rx_data !== 8'h5A || frm_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_recover: got data=%h rdy=%b ferr=%b want 5a 1 0", rx_data, rdy, frm_err);
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_clr_on_completion();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
